dctrl_master: RTL and testbench
===============================

// Module: dctrl_master
// PURPOSE
//  Synthesizable control-line master for the single-wire, half-duplex ALPIDE DCTRL link.
//  - Drives the board transceiver through dctrl_d / dctrl_de / dctrl_ren and receives on dctrl_r.
//  - Serialises write and read transactions into UART-like characters.
//  - Owns bus turnaround, collects read replies and reports status.
//  - Sits between the register-access front end and the LVDS transceiver pins.
// PARAMETERS
//  CLKS_PER_BIT     4      clk cycles per line bit (even, >=4)
//  TURNAROUND_BITS  5      bit times line is released before listening / before re-driving
//  TIMEOUT_BITS     64     bit times to wait for a reply start bit before error
//  OPCODE_WRITE     8'h9C  write opcode character
//  OPCODE_READ      8'h4E  read opcode character
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous reset, active-high
//  cmd_valid    in   1   command request
//  cmd_ready    out  1   high only in IDLE; transfer on cmd_valid & cmd_ready
//  cmd_write    in   1   1 = write, 0 = read
//  cmd_chipid   in   8   target chip id
//  cmd_addr     in   16  register address
//  cmd_wdata    in   16  write data (ignored for read)
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_data     out  16  read data (0 for writes); held until next rsp_valid
//  rsp_error    out  2   0 ok, 1 timeout, 2 framing, 3 chipid mismatch
//  tx_echo_err  out  1   sticky echo mismatch (DCTRL_ECHO_CHECK_EN only, else tied 0)
//  dctrl_d      out  1   transceiver D (line data)
//  dctrl_de     out  1   transceiver driver enable
//  dctrl_ren    out  1   transceiver receiver enable, active-low
//  dctrl_r      in   1   transceiver R (async; 2-flop synchronised internally)
// BEHAVIOUR
//  - Reset (next edge, also mid-transaction): dctrl_d=1, dctrl_de=1, dctrl_ren=1, cmd_ready=0, rsp_valid=0,
//    rsp_data=0, rsp_error=0, tx_echo_err=0, state IDLE. Aborted transaction gives no rsp_valid.
//    cmd_ready=1 from the first cycle after rst deasserts.
//  - Character: start bit 0, 8 data bits LSB first, stop bit 1. Each bit held exactly CLKS_PER_BIT cycles.
//    Back-to-back characters, no gap. Idle line is driven 1.
//  - Write: chars OPCODE_WRITE, chipid, addr[7:0], addr[15:8], wdata[7:0], wdata[15:8] (60 bits).
//  - Read: chars OPCODE_READ, chipid, addr[7:0], addr[15:8], then turnaround and receive.
//  - First start bit on dctrl_d the cycle after the handshake. cmd_* captured at handshake.
//  - States: IDLE -> TX -> (write) DONE | (read) REL -> RX_WAIT -> RX_CHAR -> (x3) -> REDRIVE -> DONE.
//  - REL: dctrl_de=0, dctrl_ren=0 for TURNAROUND_BITS*CLKS_PER_BIT cycles; then RX_WAIT.
//  - RX_WAIT: synced r==0 starts a char; timeout counter restarts for every expected char.
//    Expiry -> rsp_error=1 -> REDRIVE.
//  - RX_CHAR: sample at CLKS_PER_BIT/2 into each bit. Stop bit sampled 0 -> rsp_error=2 -> REDRIVE.
//  - Reply chars: chipid, data[7:0], data[15:8]. Chipid != cmd_chipid -> error 3.
//    Still receive all 3 chars; rsp_data=0 on any error.
//  - REDRIVE: de=0, ren=1, d=1 for TURNAROUND_BITS bit times, then de=1.
//  - DONE: rsp_valid=1 for one cycle, then IDLE with cmd_ready=1.
//  - Error priority when multiple occur: first detected wins.
//  - cmd_valid outside IDLE is ignored (not queued).
// CONFIGURATION
//  DCTRL_ECHO_CHECK_EN defined:
//  - dctrl_ren=0 also during TX.
//  - Synced dctrl_r is sampled mid-bit and compared to the driven bit, allowing 2-cycle sync latency.
//  - Mismatch sets sticky tx_echo_err; it clears only on rst. Transaction continues.
//  DCTRL_ECHO_CHECK_EN undefined: dctrl_ren=1 during TX, tx_echo_err tied 0, no compare logic.
// TESTING
//  1. Write, chipid 0x12, addr 0x0005, wdata 0xBEEF, CLKS_PER_BIT=4
//     -> line bytes 9C,12,05,00,EF,BE; rsp_valid 241 cycles after handshake; error 0.
//  2. Read, chipid 0x12, addr 0x0100; slave replies 12,34,AB after turnaround
//     -> rsp_data 0xAB34, error 0, de back to 1 after REDRIVE.
//  3. Read, no reply -> rsp_error 1 at 64*4 cycles after REL ends; line re-driven high.
//  4. Read, reply 2nd char stop bit 0 -> rsp_error 2, rsp_data 0. Reply chipid 0x13 -> rsp_error 3.
//  5. rst pulsed during TX char 3 -> next cycle d=1, de=1, no rsp_valid; new write then completes normally.
//  6. DCTRL_ECHO_CHECK_EN, bench forces dctrl_r=0 during a stop bit -> tx_echo_err=1 sticky, rsp_error 0.

Source files
------------

// File: rtl/dctrl_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : dctrl_master_if
//  Description : Command/response handshake and transceiver pin bundle for
//                the DCTRL control-line master.
//                master modport = the dctrl_master side.
//                slave  modport = the front end / transceiver side.
//  Revision    : 1.0  initial release
// ============================================================================
interface dctrl_master_if;
  // command request from the register-access front end
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_chipid;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  // completion report
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_error;
  logic        tx_echo_err;
  // transceiver pins
  logic        dctrl_d;
  logic        dctrl_de;
  logic        dctrl_ren;
  logic        dctrl_r;

  modport master (
    input  cmd_valid, cmd_write, cmd_chipid, cmd_addr, cmd_wdata, dctrl_r,
    output cmd_ready, rsp_valid, rsp_data, rsp_error, tx_echo_err,
           dctrl_d, dctrl_de, dctrl_ren
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_chipid, cmd_addr, cmd_wdata, dctrl_r,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error, tx_echo_err,
           dctrl_d, dctrl_de, dctrl_ren
  );
endinterface
`default_nettype wire

// File: rtl/dctrl_master.sv
`default_nettype none
// ============================================================================
//  Module      : dctrl_master
//  Description : Half-duplex single-wire DCTRL link master. Serialises write
//                and read transactions as UART-like characters (start 0,
//                8 data bits LSB first, stop 1), handles bus turnaround,
//                receives the 3-character read reply and reports status.
//                Optional feature macro: DCTRL_ECHO_CHECK_EN (listen to the
//                line while transmitting and flag echo mismatches).
//  Revision    : 1.0  initial release
// ============================================================================
module dctrl_master #(
  parameter int         CLKS_PER_BIT    = 4,
  parameter int         TURNAROUND_BITS = 5,
  parameter int         TIMEOUT_BITS    = 64,
  parameter logic [7:0] OPCODE_WRITE    = 8'h9C,
  parameter logic [7:0] OPCODE_READ     = 8'h4E
) (
  input  logic           clk,
  input  logic           rst,
  dctrl_master_if.master bus
);

  localparam int TRN_CYCLES = TURNAROUND_BITS * CLKS_PER_BIT;
  localparam int TO_CYCLES  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMR_MAX    = (TO_CYCLES > TRN_CYCLES) ? TO_CYCLES : TRN_CYCLES;
  localparam int TMR_W      = $clog2(TMR_MAX);
  localparam int BCLK_W     = $clog2(CLKS_PER_BIT);

  localparam logic [TMR_W-1:0]  TRN_LAST  = TMR_W'(TRN_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TO_LAST   = TMR_W'(TO_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [BCLK_W-1:0] BCLK_LAST = BCLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BCLK_W-1:0] BCLK_MID  = BCLK_W'(CLKS_PER_BIT / 2);
  localparam logic [BCLK_W-1:0] BCLK_ONE  = BCLK_W'(1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_FRAME   = 2'd2;
  localparam logic [1:0] ERR_CHIPID  = 2'd3;

`ifdef DCTRL_ECHO_CHECK_EN
  localparam logic REN_DURING_TX = 1'b0;   // receiver stays on to hear our own echo
`else
  localparam logic REN_DURING_TX = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX      = 3'd1,
    S_REL     = 3'd2,
    S_RX_WAIT = 3'd3,
    S_RX_CHAR = 3'd4,
    S_REDRIVE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t            state_q;
  logic              cmd_ready_q, rsp_valid_q;
  logic [15:0]       rsp_data_q;
  logic [1:0]        rsp_error_q, err_q;
  logic              d_q, de_q, ren_q;
  logic              wr_q;
  logic [7:0]        chipid_q;
  logic [15:0]       addr_q, wdata_q;
  logic [BCLK_W-1:0] bclk_q;      // clock index inside the current line bit
  logic [3:0]        bit_q;       // 0 start, 1..8 data, 9 stop
  logic [2:0]        chr_q;       // transmit character index
  logic [1:0]        rxchr_q;     // receive character index
  logic [TMR_W-1:0]  tmr_q;       // turnaround / timeout counter
  logic [7:0]        rx_shift_q, rx_lo_q, rx_hi_q;
  logic [1:0]        rx_sync_q;
  logic              rx_bit;
  logic [7:0]        tx_byte;
  logic [2:0]        last_chr;
  logic              next_bit;

  // Two-flop synchroniser for the asynchronous receive pin; idles high.
  always_ff @(posedge clk) begin
    if (rst) rx_sync_q <= 2'b11;
    else     rx_sync_q <= {rx_sync_q[0], bus.dctrl_r};
  end
  assign rx_bit = rx_sync_q[1];

  // Character currently being sent and the level of the bit that follows.
  always_comb begin
    tx_byte = 8'hFF;
    case (chr_q)
      3'd0:    tx_byte = wr_q ? OPCODE_WRITE : OPCODE_READ;
      3'd1:    tx_byte = chipid_q;
      3'd2:    tx_byte = addr_q[7:0];
      3'd3:    tx_byte = addr_q[15:8];
      3'd4:    tx_byte = wdata_q[7:0];
      3'd5:    tx_byte = wdata_q[15:8];
      default: tx_byte = 8'hFF;
    endcase
    last_chr = wr_q ? 3'd5 : 3'd3;
    // bit_q 0..7 is followed by data bit bit_q; bit 8 is followed by the stop bit
    next_bit = (bit_q < 4'd8) ? tx_byte[bit_q[2:0]] : 1'b1;
  end

  // Transaction sequencer: all pin and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_error_q <= ERR_NONE;
      err_q       <= ERR_NONE;
      d_q         <= 1'b1;
      de_q        <= 1'b1;
      ren_q       <= 1'b1;
      wr_q        <= 1'b0;
      chipid_q    <= 8'h00;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      bclk_q      <= '0;
      bit_q       <= 4'd0;
      chr_q       <= 3'd0;
      rxchr_q     <= 2'd0;
      tmr_q       <= '0;
      rx_shift_q  <= 8'h00;
      rx_lo_q     <= 8'h00;
      rx_hi_q     <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          d_q   <= 1'b1;
          de_q  <= 1'b1;
          ren_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            wr_q        <= bus.cmd_write;
            chipid_q    <= bus.cmd_chipid;
            addr_q      <= bus.cmd_addr;
            wdata_q     <= bus.cmd_wdata;
            cmd_ready_q <= 1'b0;
            d_q         <= 1'b0;          // first start bit goes out next cycle
            ren_q       <= REN_DURING_TX;
            bclk_q      <= '0;
            bit_q       <= 4'd0;
            chr_q       <= 3'd0;
            rxchr_q     <= 2'd0;
            err_q       <= ERR_NONE;
            state_q     <= S_TX;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        S_TX: begin
          if (bclk_q == BCLK_LAST) begin
            bclk_q <= '0;
            if (bit_q == 4'd9) begin
              if (chr_q == last_chr) begin
                d_q <= 1'b1;
                if (wr_q) begin
                  ren_q       <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= 16'h0000;
                  rsp_error_q <= ERR_NONE;
                  state_q     <= S_DONE;
                end else begin
                  de_q    <= 1'b0;
                  ren_q   <= 1'b0;
                  tmr_q   <= '0;
                  state_q <= S_REL;
                end
              end else begin
                chr_q <= chr_q + 3'd1;
                bit_q <= 4'd0;
                d_q   <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
              d_q   <= next_bit;
            end
          end else begin
            bclk_q <= bclk_q + BCLK_ONE;
          end
        end

        S_REL: begin
          if (tmr_q == TRN_LAST) begin
            tmr_q   <= '0;
            state_q <= S_RX_WAIT;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end

        S_RX_WAIT: begin
          if (!rx_bit) begin
            // the detecting cycle already counts as clock 0 of the start bit
            bclk_q  <= BCLK_ONE;
            bit_q   <= 4'd0;
            state_q <= S_RX_CHAR;
          end else if (tmr_q == TO_LAST) begin
            if (err_q == ERR_NONE) err_q <= ERR_TIMEOUT;
            ren_q   <= 1'b1;
            tmr_q   <= '0;
            state_q <= S_REDRIVE;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end

        S_RX_CHAR: begin
          if (bclk_q == BCLK_LAST) begin
            bclk_q <= '0;
            bit_q  <= bit_q + 4'd1;
          end else begin
            bclk_q <= bclk_q + BCLK_ONE;
          end
          if (bclk_q == BCLK_MID) begin
            if ((bit_q >= 4'd1) && (bit_q <= 4'd8))
              rx_shift_q <= {rx_bit, rx_shift_q[7:1]};
            if (bit_q == 4'd9) begin
              if (!rx_bit) begin
                if (err_q == ERR_NONE) err_q <= ERR_FRAME;
                ren_q   <= 1'b1;
                tmr_q   <= '0;
                state_q <= S_REDRIVE;
              end else begin
                case (rxchr_q)
                  2'd0: if ((rx_shift_q != chipid_q) && (err_q == ERR_NONE)) err_q <= ERR_CHIPID;
                  2'd1: rx_lo_q <= rx_shift_q;
                  default: rx_hi_q <= rx_shift_q;
                endcase
                tmr_q <= '0;
                if (rxchr_q == 2'd2) begin
                  ren_q   <= 1'b1;
                  state_q <= S_REDRIVE;
                end else begin
                  // leave mid-stop-bit so the next start edge is not missed
                  rxchr_q <= rxchr_q + 2'd1;
                  state_q <= S_RX_WAIT;
                end
              end
            end
          end
        end

        S_REDRIVE: begin
          if (tmr_q == TRN_LAST) begin
            de_q        <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= err_q;
            rsp_data_q  <= (err_q == ERR_NONE) ? {rx_hi_q, rx_lo_q} : 16'h0000;
            state_q     <= S_DONE;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end

        S_DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DCTRL_ECHO_CHECK_EN
  logic [1:0] echo_stb_q;
  logic [1:0] echo_exp_q;
  logic       echo_err_q;

  // Delay the mid-bit strobe and driven level by the synchroniser depth, then compare with the heard line.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_stb_q <= 2'b00;
      echo_exp_q <= 2'b11;
      echo_err_q <= 1'b0;
    end else begin
      echo_stb_q <= {echo_stb_q[0], (state_q == S_TX) && (bclk_q == BCLK_MID)};
      echo_exp_q <= {echo_exp_q[0], d_q};
      if (echo_stb_q[1] && (rx_bit != echo_exp_q[1])) echo_err_q <= 1'b1;
    end
  end
  assign bus.tx_echo_err = echo_err_q;
`else
  assign bus.tx_echo_err = 1'b0;
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.dctrl_d   = d_q;
  assign bus.dctrl_de  = de_q;
  assign bus.dctrl_ren = ren_q;

endmodule
`default_nettype wire

// File: tb/tb_dctrl_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dctrl_master
//  Description : Directed self-checking bench for dctrl_master with a simple
//                line model (master drives when de=1, else the bench slave).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dctrl_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slave_line = 1'b1;
  logic force_low  = 1'b0;
  int   cyc = 0, hs_cyc = 0;
  int   n_vec = 0, n_err = 0;

`ifdef DCTRL_ECHO_CHECK_EN
  localparam logic ECHO_EXP = 1'b1;
`else
  localparam logic ECHO_EXP = 1'b0;
`endif

  dctrl_master_if bus ();

  dctrl_master #(
    .CLKS_PER_BIT   (4),
    .TURNAROUND_BITS(5),
    .TIMEOUT_BITS   (64),
    .OPCODE_WRITE   (8'h9C),
    .OPCODE_READ    (8'h4E)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.dctrl_r = force_low ? 1'b0 : (bus.dctrl_de ? bus.dctrl_d : slave_line);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [7:0] id, input logic [15:0] addr,
                       input logic [15:0] wd);
    int budget;
    budget = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check_eq("cmd_ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = wr;
    bus.cmd_chipid = id;
    bus.cmd_addr   = addr;
    bus.cmd_wdata  = wd;
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  // Called right after the handshake edge; samples each bit at its 2nd clock.
  task automatic capture_tx(input int nchar, output logic [47:0] bytes_o, output logic frame_ok);
    logic [9:0] fr;
    bytes_o  = '0;
    frame_ok = 1'b1;
    for (int c = 0; c < nchar; c++) begin
      for (int b = 0; b < 10; b++) begin
        @(negedge clk);
        @(negedge clk);
        fr[b] = bus.dctrl_d;
        @(negedge clk);
        @(negedge clk);
      end
      if (fr[0] !== 1'b0 || fr[9] !== 1'b1) frame_ok = 1'b0;
      bytes_o[c*8 +: 8] = fr[8:1];
    end
  endtask

  task automatic wait_rsp(output int lat, output logic [15:0] data, output logic [1:0] err);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
    lat  = cyc - hs_cyc;
    data = bus.rsp_data;
    err  = bus.rsp_error;
    check_eq("rsp_valid_seen", seen, 1);
    check_eq("rsp_de_high", bus.dctrl_de, 1);
    check_eq("rsp_d_high", bus.dctrl_d, 1);
    @(negedge clk);
    check_eq("rsp_valid_one_cycle", bus.rsp_valid, 0);
    check_eq("cmd_ready_after_done", bus.cmd_ready, 1);
  endtask

  // Waits for the master to release the line, then for the turnaround to finish.
  task automatic wait_release();
    int n;
    n = 0;
    while (bus.dctrl_de !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("release_de_low", bus.dctrl_de, 0);
    check_eq("release_ren_low", bus.dctrl_ren, 0);
    repeat (22) @(posedge clk);
  endtask

  task automatic send_char(input logic [7:0] b, input logic stop_v);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      slave_line = bits[i];
      repeat (4) @(posedge clk);
      #1;
    end
    slave_line = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] bytes;
    logic        fok;
    int          lat;
    logic [15:0] rdata;
    logic [1:0]  rerr;
    int          pulses;

    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_chipid = 8'h00;
    bus.cmd_addr   = 16'h0000;
    bus.cmd_wdata  = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_d", bus.dctrl_d, 1);
    check_eq("rst_de", bus.dctrl_de, 1);
    check_eq("rst_ren", bus.dctrl_ren, 1);
    check_eq("rst_cmd_ready", bus.cmd_ready, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_data", bus.rsp_data, 0);
    check_eq("rst_rsp_error", bus.rsp_error, 0);
    check_eq("rst_echo_err", bus.tx_echo_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("cmd_ready_first_cycle", bus.cmd_ready, 1);

    // 1. Write 0x12 / 0x0005 / 0xBEEF
    issue(1'b1, 8'h12, 16'h0005, 16'hBEEF);
    capture_tx(6, bytes, fok);
    check_eq("wr1_bytes", bytes, 48'hBEEF_0005_129C);
    check_eq("wr1_framing", fok, 1);
    wait_rsp(lat, rdata, rerr);
    check_eq("wr1_latency", lat, 240);   // handshake cycle = 0, rsp_valid in cycle 241
    check_eq("wr1_error", rerr, 0);
    check_eq("wr1_data", rdata, 0);

    // 2. Read 0x12 / 0x0100, reply 12 34 AB
    issue(1'b0, 8'h12, 16'h0100, 16'h0000);
    capture_tx(4, bytes, fok);
    check_eq("rd2_bytes", bytes[31:0], 32'h0100_124E);
    check_eq("rd2_framing", fok, 1);
    wait_release();
    send_char(8'h12, 1'b1);
    send_char(8'h34, 1'b1);
    send_char(8'hAB, 1'b1);
    wait_rsp(lat, rdata, rerr);
    check_eq("rd2_data", rdata, 16'hAB34);
    check_eq("rd2_error", rerr, 0);

    // 3. Read, no reply: 160 tx + 20 release + 256 timeout + 20 redrive
    issue(1'b0, 8'h12, 16'h0200, 16'h0000);
    wait_rsp(lat, rdata, rerr);
    check_eq("rd3_latency", lat, 456);
    check_eq("rd3_error", rerr, 1);
    check_eq("rd3_data", rdata, 0);
    check_eq("rd3_ren_high", bus.dctrl_ren, 1);

    // 4a. Second reply char with stop bit 0
    issue(1'b0, 8'h12, 16'h0300, 16'h0000);
    wait_release();
    send_char(8'h12, 1'b1);
    send_char(8'h34, 1'b0);
    wait_rsp(lat, rdata, rerr);
    check_eq("rd4_frame_error", rerr, 2);
    check_eq("rd4_frame_data", rdata, 0);

    // 4b. Reply chipid 0x13
    issue(1'b0, 8'h12, 16'h0400, 16'h0000);
    wait_release();
    send_char(8'h13, 1'b1);
    send_char(8'h34, 1'b1);
    send_char(8'hAB, 1'b1);
    wait_rsp(lat, rdata, rerr);
    check_eq("rd4_chipid_error", rerr, 3);
    check_eq("rd4_chipid_data", rdata, 0);

    // 5. Reset pulsed during the third transmitted character
    issue(1'b1, 8'h21, 16'h1234, 16'h5678);
    repeat (90) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_d", bus.dctrl_d, 1);
    check_eq("abort_de", bus.dctrl_de, 1);
    check_eq("abort_cmd_ready", bus.cmd_ready, 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
    end
    check_eq("abort_no_rsp", pulses, 0);
    issue(1'b1, 8'h5A, 16'hC3A5, 16'h0F1E);
    capture_tx(6, bytes, fok);
    check_eq("wr5_bytes", bytes, 48'h0F1E_C3A5_5A9C);
    wait_rsp(lat, rdata, rerr);
    check_eq("wr5_latency", lat, 240);
    check_eq("wr5_error", rerr, 0);
    check_eq("echo_clean_so_far", bus.tx_echo_err, 0);

    // 6. Line forced low during the stop bit of the first character
    issue(1'b1, 8'h12, 16'h0005, 16'hBEEF);
    repeat (36) @(posedge clk);
    #1;
    force_low = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    force_low = 1'b0;
    wait_rsp(lat, rdata, rerr);
    check_eq("echo_rsp_error", rerr, 0);
    check_eq("echo_err_set", bus.tx_echo_err, ECHO_EXP);
    issue(1'b1, 8'h12, 16'h0006, 16'h0001);
    wait_rsp(lat, rdata, rerr);
    check_eq("echo_err_sticky", bus.tx_echo_err, ECHO_EXP);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("echo_err_rst_clear", bus.tx_echo_err, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
